// File: rtl/ch_mean_pkg.sv
// Shared types and widths for the channel_mean statistics block.
// The widths here are the defaults; the top recomputes them from its own parameter.
package ch_mean_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    DIV_R = 3'd2,
    DIV_G = 3'd3,
    DIV_B = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int MAX_PIXELS_LOG2_DEF = 20;
  localparam int CNT_W     = MAX_PIXELS_LOG2_DEF + 1;
  localparam int SUM_W     = 8 + MAX_PIXELS_LOG2_DEF;
  localparam int DIV_STEPS = 8;

  function automatic int cnt_w_of(input int log2);
    return log2 + 1;
  endfunction

  function automatic int sum_w_of(input int log2);
    return log2 + 8;
  endfunction

endpackage

// File: rtl/channel_mean_div.sv
// Sequential restoring divider producing an 8-bit quotient, one bit per cycle, MSB first.
// The start cycle performs the first step directly on i_dividend, so done is seen on the 8th cycle.
module channel_mean_div
  import ch_mean_pkg::*;
#(
  parameter int DIVD_W = SUM_W,
  parameter int DIVS_W = CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [DIVD_W-1:0] i_dividend,
  input  logic [DIVS_W-1:0] i_divisor,
  output logic [7:0]        o_quotient,
  output logic              o_done
);

  logic              r_active;
  logic [2:0]        r_idx;
  logic [DIVD_W-1:0] r_rem;
  logic [7:0]        r_q;

  logic              w_step;
  logic [2:0]        w_idx;
  logic [DIVD_W-1:0] w_rem_in;
  logic [DIVD_W-1:0] w_trial;
  logic              w_ge;
  logic [DIVD_W-1:0] w_rem_nxt;
  logic [7:0]        w_q_nxt;

  always_comb begin
    w_step    = i_start | r_active;
    w_idx     = i_start ? 3'(DIV_STEPS - 1) : r_idx;
    w_rem_in  = i_start ? i_dividend : r_rem;
    // divisor << 7 still fits because DIVD_W = DIVS_W + 7
    w_trial   = DIVD_W'(i_divisor) << w_idx;
    w_ge      = (w_rem_in >= w_trial);
    w_rem_nxt = w_ge ? (w_rem_in - w_trial) : w_rem_in;
    w_q_nxt   = (i_start ? 8'd0 : r_q) | (w_ge ? (8'd1 << w_idx) : 8'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active <= 1'b0;
      r_idx    <= 3'd0;
      r_rem    <= '0;
      r_q      <= 8'd0;
    end else if (w_step) begin
      r_rem    <= w_rem_nxt;
      r_q      <= w_q_nxt;
      r_idx    <= 3'(w_idx - 3'd1);
      r_active <= (w_idx != 3'd0);
    end
  end

  assign o_quotient = w_q_nxt;
  assign o_done     = w_step && (w_idx == 3'd0);

endmodule

// File: rtl/channel_mean.sv
// Per-frame R/G/B floor means over a streamed pixel bus, using one shared divider three times.
// valid_o/busy_o follow state; the three means update on the same edge that enters DONE.
module channel_mean
  import ch_mean_pkg::*;
#(
  parameter int MAX_PIXELS_LOG2 = MAX_PIXELS_LOG2_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_i,
  input  logic       sof_i,
  input  logic       eof_i,
  input  logic [7:0] r_i,
  input  logic [7:0] g_i,
  input  logic [7:0] b_i,
  output logic [7:0] r_mean_o,
  output logic [7:0] g_mean_o,
  output logic [7:0] b_mean_o,
  output logic       valid_o,
  output logic       busy_o,
  output logic       err_o,
  output logic [2:0] state_o
);

  localparam int CW = cnt_w_of(MAX_PIXELS_LOG2);
  localparam int SW = sum_w_of(MAX_PIXELS_LOG2);
  localparam logic [CW-1:0] MAX_CNT = CW'(1) << MAX_PIXELS_LOG2;

  state_t          r_state;
  logic [SW-1:0]   r_sum_r, r_sum_g, r_sum_b;
  logic [CW-1:0]   r_count;
  logic [7:0]      r_hold_r, r_hold_g;
  logic [7:0]      r_mean_r, r_mean_g, r_mean_b;
  logic            r_start;
  logic            r_err;

  state_t          w_nxt;
  logic            w_load, w_add, w_err, w_start;
  logic [SW-1:0]   w_dividend;
  logic [7:0]      w_quot;
  logic            w_div_done;

  // Valid/ready: there is no ready; a beat counts only when valid_i is high and the state accepts it.
  always_comb begin
    w_nxt  = r_state;
    w_load = 1'b0;
    w_add  = 1'b0;
    w_err  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (valid_i && sof_i) begin
          w_load = 1'b1;
          w_nxt  = eof_i ? DIV_R : ACCUM;
        end
      end
      ACCUM: begin
        if (valid_i) begin
          if (sof_i) begin
            w_load = 1'b1;
            w_err  = 1'b1;
          end else if (r_count == MAX_CNT) begin
            w_err  = 1'b1;
          end else begin
            w_add  = 1'b1;
          end
          if (eof_i) w_nxt = DIV_R;
        end
      end
      DIV_R: begin
        w_err = valid_i && sof_i;
        if (w_div_done) w_nxt = DIV_G;
      end
      DIV_G: begin
        w_err = valid_i && sof_i;
        if (w_div_done) w_nxt = DIV_B;
      end
      DIV_B: begin
        w_err = valid_i && sof_i;
        if (w_div_done) w_nxt = DONE;
      end
      DONE: begin
        w_err = valid_i && sof_i;
        w_nxt = IDLE;
      end
      default: w_nxt = IDLE;
    endcase
    w_start = (w_nxt != r_state) && (w_nxt == DIV_R || w_nxt == DIV_G || w_nxt == DIV_B);
  end

  always_comb begin
    w_dividend = r_sum_r;
    if (r_state == DIV_G) w_dividend = r_sum_g;
    if (r_state == DIV_B) w_dividend = r_sum_b;
  end

  channel_mean_div #(
    .DIVD_W (SW),
    .DIVS_W (CW)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (r_start),
    .i_dividend (w_dividend),
    .i_divisor  (r_count),
    .o_quotient (w_quot),
    .o_done     (w_div_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_sum_r  <= '0;
      r_sum_g  <= '0;
      r_sum_b  <= '0;
      r_count  <= '0;
      r_hold_r <= 8'd0;
      r_hold_g <= 8'd0;
      r_mean_r <= 8'd0;
      r_mean_g <= 8'd0;
      r_mean_b <= 8'd0;
      r_start  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_start <= w_start;
      r_err   <= w_err;
      if (w_load) begin
        r_sum_r <= SW'(r_i);
        r_sum_g <= SW'(g_i);
        r_sum_b <= SW'(b_i);
        r_count <= CW'(1);
      end else if (w_add) begin
        r_sum_r <= r_sum_r + SW'(r_i);
        r_sum_g <= r_sum_g + SW'(g_i);
        r_sum_b <= r_sum_b + SW'(b_i);
        r_count <= r_count + CW'(1);
      end
      if (w_div_done && r_state == DIV_R) r_hold_r <= w_quot;
      if (w_div_done && r_state == DIV_G) r_hold_g <= w_quot;
      // Blue comes straight from the divider so all three land together entering DONE
      if (w_div_done && r_state == DIV_B) begin
        r_mean_r <= r_hold_r;
        r_mean_g <= r_hold_g;
        r_mean_b <= w_quot;
      end
    end
  end

  assign r_mean_o = r_mean_r;
  assign g_mean_o = r_mean_g;
  assign b_mean_o = r_mean_b;
  assign valid_o  = (r_state == DONE);
  assign busy_o   = (r_state == DIV_R) || (r_state == DIV_G) || (r_state == DIV_B) || (r_state == DONE);
  assign err_o    = r_err;
  assign state_o  = r_state;

endmodule

// File: tb/tb_channel_mean.sv
// Directed bench for channel_mean: a default-size instance and a 4-pixel-limit instance share the pixel bus.
// Expected means and completion cycles are queued at stimulus time and checked by negedge monitors.
module tb_channel_mean;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid_a = 1'b0, valid_b = 1'b0;
  logic       sof_i = 1'b0, eof_i = 1'b0;
  logic [7:0] r_i = 8'd0, g_i = 8'd0, b_i = 8'd0;

  logic [7:0] ra, ga, ba, rb, gb, bb;
  logic       valid_oa, busy_oa, err_oa, valid_ob, busy_ob, err_ob;
  logic [2:0] state_a, state_b;

  channel_mean dut_a (
    .clk(clk), .rst(rst), .valid_i(valid_a), .sof_i(sof_i), .eof_i(eof_i),
    .r_i(r_i), .g_i(g_i), .b_i(b_i),
    .r_mean_o(ra), .g_mean_o(ga), .b_mean_o(ba),
    .valid_o(valid_oa), .busy_o(busy_oa), .err_o(err_oa), .state_o(state_a)
  );

  channel_mean #(.MAX_PIXELS_LOG2(2)) dut_b (
    .clk(clk), .rst(rst), .valid_i(valid_b), .sof_i(sof_i), .eof_i(eof_i),
    .r_i(r_i), .g_i(g_i), .b_i(b_i),
    .r_mean_o(rb), .g_mean_o(gb), .b_mean_o(bb),
    .valid_o(valid_ob), .busy_o(busy_ob), .err_o(err_ob), .state_o(state_b)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  logic [23:0] exp_q[$];
  int          cyc_q[$];
  logic [23:0] exp_b_q[$];
  int          cyc_b_q[$];
  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;
  int err_cnt_a = 0;
  int err_cnt_b = 0;
  logic [23:0] mon_e;
  int          mon_c;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (busy_oa) busy_cnt++;
      if (err_oa) err_cnt_a++;
      if (err_ob) err_cnt_b++;
      if (valid_oa) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid_a means=%0d/%0d/%0d cycle=%0d", ra, ga, ba, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          mon_c = cyc_q.pop_front();
          check("r_mean_a", int'(ra), int'(mon_e[23:16]));
          check("g_mean_a", int'(ga), int'(mon_e[15:8]));
          check("b_mean_a", int'(ba), int'(mon_e[7:0]));
          check("latency_a", cyc, mon_c);
        end
      end
      if (valid_ob) begin
        if (exp_b_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid_b means=%0d/%0d/%0d cycle=%0d", rb, gb, bb, cyc);
        end else begin
          mon_e = exp_b_q.pop_front();
          mon_c = cyc_b_q.pop_front();
          check("means_b", int'({rb, gb, bb}), int'(mon_e));
          check("latency_b", cyc, mon_c);
        end
      end
    end
  end

  // drivers (called at a negedge, return at the next negedge)
  task automatic beat(input bit to_b, input bit sof, input bit eof,
                      input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    valid_a = !to_b;
    valid_b = to_b;
    sof_i = sof;
    eof_i = eof;
    r_i = r;
    g_i = g;
    b_i = b;
    @(negedge clk);
    valid_a = 1'b0;
    valid_b = 1'b0;
    sof_i = 1'b0;
    eof_i = 1'b0;
  endtask

  task automatic expect_a(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    exp_q.push_back({r, g, b});
    cyc_q.push_back(cyc + 25);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_b_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || exp_b_q.size() != 0) begin
      check("result_timeout", exp_q.size() + exp_b_q.size(), 0);
      exp_q.delete();
      cyc_q.delete();
      exp_b_q.delete();
      cyc_b_q.delete();
    end
    @(negedge clk);
  endtask

  int base;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_means", int'({ra, ga, ba}), 0);
    check("reset_valid", int'(valid_oa), 0);
    check("reset_busy", int'(busy_oa), 0);
    check("reset_err", int'(err_oa), 0);
    check("reset_state", int'(state_a), 0);

    // 4-pixel flat frame
    base = err_cnt_a;
    beat(0, 1, 0, 8'd10, 8'd20, 8'd30);
    beat(0, 0, 0, 8'd10, 8'd20, 8'd30);
    beat(0, 0, 0, 8'd10, 8'd20, 8'd30);
    expect_a(8'd10, 8'd20, 8'd30);
    beat(0, 0, 1, 8'd10, 8'd20, 8'd30);
    wait_done();
    check("flat_err", err_cnt_a - base, 0);

    // floor rounding
    beat(0, 1, 0, 8'd1, 8'd255, 8'd0);
    beat(0, 0, 0, 8'd2, 8'd255, 8'd0);
    expect_a(8'd1, 8'd255, 8'd0);
    beat(0, 0, 1, 8'd2, 8'd255, 8'd1);
    wait_done();

    // single-pixel frame, busy window length
    busy_cnt = 0;
    expect_a(8'd200, 8'd0, 8'd128);
    beat(0, 1, 1, 8'd200, 8'd0, 8'd128);
    wait_done();
    check("busy_cycles", busy_cnt, 25);

    // restart mid-frame
    base = err_cnt_a;
    beat(0, 1, 0, 8'd50, 8'd50, 8'd50);
    beat(0, 0, 0, 8'd50, 8'd50, 8'd50);
    beat(0, 1, 0, 8'd100, 8'd100, 8'd100);
    expect_a(8'd100, 8'd100, 8'd100);
    beat(0, 0, 1, 8'd100, 8'd100, 8'd100);
    wait_done();
    check("restart_err", err_cnt_a - base, 1);

    // beats during busy are ignored; only the sof one flags an error
    base = err_cnt_a;
    expect_a(8'd7, 8'd8, 8'd9);
    beat(0, 1, 1, 8'd7, 8'd8, 8'd9);
    repeat (2) @(negedge clk);
    beat(0, 0, 1, 8'd250, 8'd250, 8'd250);
    beat(0, 1, 1, 8'd250, 8'd250, 8'd250);
    wait_done();
    check("busy_sof_err", err_cnt_a - base, 1);
    repeat (3) @(negedge clk);
    check("means_held", int'({ra, ga, ba}), int'({8'd7, 8'd8, 8'd9}));
    check("idle_after_done", int'(state_a), 0);

    // reset in the third DIV_G cycle aborts the frame
    beat(0, 1, 1, 8'd40, 8'd50, 8'd60);
    repeat (10) @(negedge clk);
    check("pre_abort_state", int'(state_a), 3);
    rst = 1'b1;
    #1;
    check("abort_means", int'({ra, ga, ba}), 0);
    check("abort_busy", int'(busy_oa), 0);
    check("abort_valid", int'(valid_oa), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_idle", int'(state_a), 0);

    // overflow on the 4-pixel-limit instance
    base = err_cnt_b;
    beat(1, 1, 0, 8'd4, 8'd4, 8'd4);
    beat(1, 0, 0, 8'd4, 8'd4, 8'd4);
    beat(1, 0, 0, 8'd4, 8'd4, 8'd4);
    beat(1, 0, 0, 8'd4, 8'd4, 8'd4);
    beat(1, 0, 0, 8'd200, 8'd200, 8'd200);
    exp_b_q.push_back({8'd4, 8'd4, 8'd4});
    cyc_b_q.push_back(cyc + 25);
    beat(1, 0, 1, 8'd200, 8'd200, 8'd200);
    wait_done();
    check("overflow_err", err_cnt_b - base, 2);
    check("overflow_r_mean", int'(rb), 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/channel_mean.md
Name: channel_mean

Overview:
- Upstream statistics stage for the white-balance gain divider.
- Accumulates per-channel R/G/B sums over one frame of a streamed RGB pixel bus, counts the accepted pixels, then computes the three 8-bit floor means with one shared sequential restoring divider.
- Presents r/g/b means with a one-cycle valid pulse that drives the gain stage's valid_i and mean inputs directly.

Parameters:
- MAX_PIXELS_LOG2, 20: frame-size limit is 2^MAX_PIXELS_LOG2 pixels. Pixel counter is MAX_PIXELS_LOG2+1 bits; sum registers are 8+MAX_PIXELS_LOG2 bits.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- valid_i  input  1  pixel beat valid
- sof_i  input  1  start of frame, qualified by valid_i
- eof_i  input  1  end of frame (last pixel), qualified by valid_i
- r_i, g_i, b_i  input  8 each  pixel components
- r_mean_o, g_mean_o, b_mean_o  output  8 each  frame means, held until the next result
- valid_o  output  1  one-cycle pulse; means are new this cycle
- busy_o  output  1  high in DIV_R, DIV_G, DIV_B and DONE
- err_o  output  1  one-cycle pulse on a protocol or overflow event

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; sums, count and divider registers 0. Reset mid-division aborts it; no valid_o follows.
- Beat accepted = valid_i=1 in IDLE with sof_i=1, or valid_i=1 in ACCUM.
- IDLE:
  - valid_i&sof_i: sums load the pixel, count=1, go to ACCUM.
  - If eof_i is also 1 (single-pixel frame), go to DIV_R instead.
  - valid_i without sof_i: ignored, no error.
- ACCUM:
  - Each accepted beat adds r/g/b to the sums and increments count.
  - valid_i&sof_i: restart. Sums and count reload from this pixel; the partial frame is discarded and err_o pulses.
  - valid_i&eof_i: pixel is included, then go to DIV_R.
  - Overflow: once count = 2^MAX_PIXELS_LOG2, further beats are not added and err_o pulses once per dropped beat. eof_i is still honoured.
- DIV_R, DIV_G, DIV_B: 8 cycles each, quotient bits MSB first.
  - Step i=7..0: if rem >= (count<<i) then rem -= (count<<i) and q[i]=1, else q[i]=0.
  - rem initialises to the channel sum on state entry.
  - floor(sum/count) <= 255 always holds, so no quotient overflow.
  - Quotients go to internal holding registers.
- DONE (1 cycle): all three holding registers copy to r/g/b_mean_o together, valid_o=1, then go to IDLE. No partially updated mean is ever visible.
- Latency: eof beat accepted at edge T. DIV_R occupies T+1..T+8, DIV_G T+9..T+16, DIV_B T+17..T+24. DONE and valid_o are at cycle T+25.
- While busy_o=1, all valid_i beats are ignored. A sof_i beat during busy also pulses err_o (frame dropped).
- The beat in the cycle after DONE (IDLE) is accepted normally.
- Rounding: truncation. Count is never 0 on divider entry.

Decomposition:
- Shared package ch_mean_pkg holds:
  - state enum IDLE, ACCUM, DIV_R, DIV_G, DIV_B, DONE;
  - localparams CNT_W = MAX_PIXELS_LOG2+1 and SUM_W = 8+MAX_PIXELS_LOG2;
  - DIV_STEPS = 8.
- One sub-module: channel_mean_div, the sequential restoring divider.
  - Interface: start, dividend[SUM_W], divisor[CNT_W]; outputs quotient[8], done.
  - Reused three times serially by the top FSM.

Test Plan:
- 4-pixel frame, every pixel (10,20,30), sof on first and eof on last -> valid_o exactly 25 cycles after the eof edge; means 10/20/30; err_o never asserted.
- 3-pixel frame R=1,2,2; G=255,255,255; B=0,0,1 -> means R=1, G=255, B=0 (floor).
- Single beat with sof_i=eof_i=1, pixel (200,0,128) -> means 200/0/128; busy_o high for exactly 25 cycles.
- Frame A: 2 pixels of (50,50,50), then sof_i with (100,100,100) and eof 1 beat later with (100,100,100) -> err_o pulse at the restart; means 100/100/100.
- Beats (sof and non-sof) driven during busy -> ignored; err_o pulses on the sof beat; means unchanged. Assert rst at DIV_G cycle 3 -> outputs 0 immediately, no valid_o.
- MAX_PIXELS_LOG2=2, 6-beat frame R=4,4,4,4,200,200 with eof on beat 6 -> err_o on beats 5 and 6; r_mean_o=4.
